// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one BLOCK-bit
// slice with a flat lookahead network and registers the slice carry-out for the
// next stage. Each stage's data register packs {sum_done, b_rem, a_rem}. As a
// slice is consumed, its operand bits leave and its sum bits join at the top, so
// the register narrows by BLOCK bits per stage and no dead bits are carried.

module pipelined_cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);
  logic [BLOCK-1:0] g, p;
  logic [BLOCK:0]   c;
  logic             term;

  // Every carry is a flat sum-of-products of g, p and ci; no carry feeds another.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    for (int i = 0; i <= BLOCK; i++) begin
      term = ci;
      for (int k = 0; k < i; k++) term = term & p[k];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    s  = p ^ c[BLOCK-1:0];
    co = c[BLOCK];
  end
endmodule

module pipelined_cla_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH:0]   final_sum
);
  // WIDTH must be a multiple of BLOCK
  localparam int NUM_STAGES = WIDTH / BLOCK;

  logic advance;
  logic ov_nxt, ov_d, ov_q;

  // Whole pipeline moves in lockstep; it only stalls when a full output is refused.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
    localparam int R  = WIDTH - k*BLOCK;          // operand bits still unresolved
    localparam int XW = 2*R + k*BLOCK;            // stage input: {sum_done, b_rem, a_rem}
    localparam logic [XW-1:0] MASK_A = (XW'(1) << (R - BLOCK)) - XW'(1);

    logic [XW-1:0]       x;
    logic                xc, xv;
    logic [BLOCK-1:0]    s_blk;
    logic                co_blk;
    logic [XW-BLOCK-1:0] dat_d, dat_q;
    logic                c_d, c_q, v_d, v_q;

    if (k == 0) begin : g_in
      // Subtract is a + ~b + 1, so cin is replaced by 1 when sub is set.
      assign x  = {(sub ? ~b : b), a};
      assign xc = sub | cin;
      assign xv = in_valid;
    end else begin : g_chain
      assign x  = g_stg[k-1].dat_q;
      assign xc = g_stg[k-1].c_q;
      assign xv = g_stg[k-1].v_q;
    end

    pipelined_cla_block #(.BLOCK(BLOCK)) u_cla (
      .a  (x[BLOCK-1:0]),
      .b  (x[R +: BLOCK]),
      .ci (xc),
      .s  (s_blk),
      .co (co_blk)
    );

    // Drop this slice's operand bits and append its sum slice on top of the done bits.
    always_comb begin
      dat_d = dat_q;
      c_d   = c_q;
      v_d   = v_q;
      if (advance) begin
        dat_d = (XW-BLOCK)'((XW'(s_blk) << (XW - 2*BLOCK))
                          | ((x >> BLOCK)   &  MASK_A)
                          | ((x >> 2*BLOCK) & ~MASK_A));
        c_d   = co_blk;
        v_d   = xv;
      end
    end

    // Stage register; reset clears data as well so the outputs read zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        dat_q <= '0;
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else begin
        dat_q <= dat_d;
        c_q   <= c_d;
        v_q   <= v_d;
      end
    end

    if (k == NUM_STAGES - 1) begin : g_last
      // Carry into the MSB is a^b^s there, so overflow needs no extra carry tap.
      assign ov_nxt = x[BLOCK-1] ^ x[R+BLOCK-1] ^ s_blk[BLOCK-1] ^ co_blk;
    end
  end

  // Overflow flag rides in the output stage and holds with it.
  always_comb begin
    ov_d = ov_q;
    if (advance) ov_d = ov_nxt;
  end

  // Overflow register.
  always_ff @(posedge clk) begin
    if (rst) ov_q <= 1'b0;
    else     ov_q <= ov_d;
  end

  assign out_valid = g_stg[NUM_STAGES-1].v_q;
  assign sum       = g_stg[NUM_STAGES-1].dat_q;
  assign cout      = g_stg[NUM_STAGES-1].c_q;
  assign overflow  = ov_q;
  assign final_sum = {cout, sum};
endmodule
